text_fetch: RTL

TEXT_FETCH -- requirements
Module: text_fetch

---
 rtl/zed64_vid_pkg.sv | 11 +
 rtl/vid_delay.sv | 24 ++
 rtl/text_fetch.sv | 103 ++++++++++
 3 files changed

// File: rtl/zed64_vid_pkg.sv
// Shared video constants for the zed64 display path.
// Used by both vidcon and text_fetch.
package zed64_vid_pkg;
    localparam int CELL_W  = 8;
    localparam int CELL_H  = 8;
    localparam int COLS    = 128;
    localparam int LATENCY = 4;
    localparam int RGB_W   = 12;

    typedef logic [RGB_W-1:0] rgb444_t;
endpackage

// File: rtl/vid_delay.sv
// Fixed-depth register delay line with async clear.
// Keeps beam-side signals aligned with the fetch pipeline.
module vid_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];
endmodule

// File: rtl/text_fetch.sv
// 8x8 character-cell text renderer: VRAM fetch, chargen lookup,
// glyph shift-out and blinking block cursor.
module text_fetch
    import zed64_vid_pkg::*;
#(
    parameter int COLS    = zed64_vid_pkg::COLS,
    parameter int LATENCY = zed64_vid_pkg::LATENCY
) (
    input  logic        pix_clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic        de,
    input  logic [15:0] text_base,
    input  rgb444_t     fg_color,
    input  rgb444_t     bg_color,
    input  logic        cursor_en,
    input  logic [13:0] cursor_pos,
    output logic [15:0] vpu_addr,
    input  logic [7:0]  vram_data_in,
    output logic [11:0] char_addr,
    input  logic [7:0]  char_data,
    output rgb444_t     pix_rgb,
    output logic        pix_de
);
    localparam logic [15:0] STRIDE = 16'(COLS);

    logic        fetch;
    logic [15:0] cell_off;
    logic        cur_hit;
    logic [5:0]  frame_cnt;
    logic [7:0]  glyph;
    logic        de_d3;
    logic [2:0]  off_d3;
    logic [2:0]  line_d2;
    logic        load_d2;
    logic        hit_d2;

    assign fetch    = de && (hcount[2:0] == 3'd0);
    assign cell_off = STRIDE * {9'd0, vcount[9:3]} + {8'd0, hcount[10:3]};
    assign cur_hit  = cursor_en && frame_cnt[5]
                   && (cell_off[13:0] == cursor_pos);

    vid_delay #(.WIDTH(1), .DEPTH(LATENCY-1)) u_de (
        .clk(pix_clk), .reset(reset), .din(de), .dout(de_d3)
    );

    vid_delay #(.WIDTH(3), .DEPTH(LATENCY-1)) u_off (
        .clk(pix_clk), .reset(reset), .din(hcount[2:0]), .dout(off_d3)
    );

    vid_delay #(.WIDTH(3), .DEPTH(2)) u_line (
        .clk(pix_clk), .reset(reset), .din(vcount[2:0]), .dout(line_d2)
    );

    // Load strobe travels with the cursor match so inversion tracks its cell.
    vid_delay #(.WIDTH(2), .DEPTH(2)) u_hit (
        .clk(pix_clk), .reset(reset),
        .din({fetch, cur_hit}), .dout({load_d2, hit_d2})
    );

    assign char_addr = {1'b0, vram_data_in, line_d2};

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            vpu_addr <= '0;
        end else if (fetch) begin
            vpu_addr <= text_base + cell_off;
        end
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (hcount == 11'd0 && vcount == 10'd0) begin
            frame_cnt <= frame_cnt + 6'd1;
        end
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            glyph <= '0;
        end else if (load_d2) begin
            glyph <= char_data ^ {8{hit_d2}};
        end
    end

    always_ff @(posedge pix_clk or posedge reset) begin
        if (reset) begin
            pix_rgb <= '0;
            pix_de  <= 1'b0;
        end else begin
            pix_de <= de_d3;
            if (!de_d3) begin
                pix_rgb <= '0;
            end else if (glyph[3'd7 - off_d3]) begin
                pix_rgb <= fg_color;
            end else begin
                pix_rgb <= bg_color;
            end
        end
    end
endmodule
